// File: rtl/fw_scoreboard_pkg.sv
// Shared encodings for the D-stage forwarding scoreboard: operand source
// selects, the "operand unused" Tuse marker and per-opcode Tnew/Tuse values.
package fw_scoreboard_pkg;

  typedef enum logic [1:0] {
    SRC_GRF = 2'd0,
    SRC_E   = 2'd1,
    SRC_M   = 2'd2,
    SRC_W   = 2'd3
  } src_e;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew at E entry, by opcode class.
  localparam logic [1:0] TNEW_LW  = 2'd2;
  localparam logic [1:0] TNEW_ALU = 2'd1;  // addu, subu, ori, lui
  localparam logic [1:0] TNEW_JAL = 2'd0;

  // Tuse in D, by operand role.
  localparam logic [1:0] TUSE_BEQ     = 2'd0;
  localparam logic [1:0] TUSE_ALU     = 2'd1;
  localparam logic [1:0] TUSE_SW_DATA = 2'd2;

endpackage

// File: rtl/fw_scoreboard_if.sv
// D-stage operand request, E/M/W forwarding bus and scoreboard results.
// The pipeline side is the master; the scoreboard is the slave.
interface fw_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] d_rs_addr;
  logic [ADDR_W-1:0] d_rt_addr;
  logic [TNEW_W-1:0] d_rs_tuse;
  logic [TNEW_W-1:0] d_rt_tuse;
  logic [ADDR_W-1:0] d_dst_addr;
  logic [TNEW_W-1:0] d_dst_tnew;
  logic [DATA_W-1:0] grf_rs_data;
  logic [DATA_W-1:0] grf_rt_data;
  logic [ADDR_W-1:0] e_fw_addr;
  logic [DATA_W-1:0] e_fw_value;
  logic [ADDR_W-1:0] m_fw_addr;
  logic [DATA_W-1:0] m_fw_value;
  logic [ADDR_W-1:0] w_fw_addr;
  logic [DATA_W-1:0] w_fw_value;

  logic              stall;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [1:0]        rs_src;
  logic [1:0]        rt_src;
  logic              rs_pending;
  logic              rt_pending;
  logic              sb_mismatch;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse, d_dst_addr, d_dst_tnew,
           grf_rs_data, grf_rt_data,
           e_fw_addr, e_fw_value, m_fw_addr, m_fw_value, w_fw_addr, w_fw_value,
    input  stall, rs_data, rt_data, rs_src, rt_src, rs_pending, rt_pending,
           sb_mismatch, stall_cnt
  );

  modport slave (
    input  d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse, d_dst_addr, d_dst_tnew,
           grf_rs_data, grf_rt_data,
           e_fw_addr, e_fw_value, m_fw_addr, m_fw_value, w_fw_addr, w_fw_value,
    output stall, rs_data, rt_data, rs_src, rt_src, rs_pending, rt_pending,
           sb_mismatch, stall_cnt
  );
endinterface

// File: rtl/fw_scoreboard_resolve.sv
// Resolves one D-stage source operand against the E/M/W slots: picks the
// nearest producer and decides bypass, pending re-forward or stall.
module fw_resolve
  import fw_scoreboard_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int TNEW_W = 2
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [TNEW_W-1:0] tuse,
  input  logic [ADDR_W-1:0] slot_addr [3],
  input  logic [TNEW_W-1:0] slot_tnew [3],
  input  logic [DATA_W-1:0] fw_value  [3],
  input  logic [DATA_W-1:0] grf_data,
  output logic [DATA_W-1:0] data,
  output src_e              src,
  output logic              pending,
  output logic              stall
);

  logic hit;
  int   idx;

  always_comb begin
    // NOTE: every output is defaulted first so no path can leave a latch.
    data    = grf_data;
    src     = SRC_GRF;
    pending = 1'b0;
    stall   = 1'b0;
    hit     = 1'b0;
    idx     = 0;
    if (addr != '0 && tuse != TNEW_W'(TUSE_NONE)) begin
      // Scan W..E so the last hit written is the nearest producer.
      for (int i = 2; i >= 0; i--) begin
        if (slot_addr[i] == addr) begin
          hit = 1'b1;
          idx = i;
        end
      end
      if (hit) begin
        if (slot_tnew[idx] == '0) begin
          data = fw_value[idx];
          case (idx)
            0:       src = SRC_E;
            1:       src = SRC_M;
            default: src = SRC_W;
          endcase
        end else if (slot_tnew[idx] <= tuse) begin
          pending = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fw_scoreboard.sv
// D-stage forwarding scoreboard: tracks in-flight destinations in E/M/W,
// drives stall/bypass for rs and rt, and cross-checks the forwarding bus.
module fw_scoreboard
  import fw_scoreboard_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           reset,
  fw_scoreboard_if.slave bus
);

  // Slot index 0 = E, 1 = M, 2 = W.
  logic [ADDR_W-1:0] slot_addr [3];
  logic [TNEW_W-1:0] slot_tnew [3];
  logic [ADDR_W-1:0] fw_addr   [3];
  logic [DATA_W-1:0] fw_value  [3];

  logic             rs_stall;
  logic             rt_stall;
  src_e             rs_src_sel;
  src_e             rt_src_sel;
  logic             stall;
  logic             check_fail;
  logic             sb_mismatch_q;
  logic [CNT_W-1:0] stall_cnt_q;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  assign fw_addr[0]  = bus.e_fw_addr;
  assign fw_addr[1]  = bus.m_fw_addr;
  assign fw_addr[2]  = bus.w_fw_addr;
  assign fw_value[0] = bus.e_fw_value;
  assign fw_value[1] = bus.m_fw_value;
  assign fw_value[2] = bus.w_fw_value;

  fw_resolve #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TNEW_W(TNEW_W)) u_rs (
    .addr      (bus.d_rs_addr),
    .tuse      (bus.d_rs_tuse),
    .slot_addr (slot_addr),
    .slot_tnew (slot_tnew),
    .fw_value  (fw_value),
    .grf_data  (bus.grf_rs_data),
    .data      (bus.rs_data),
    .src       (rs_src_sel),
    .pending   (bus.rs_pending),
    .stall     (rs_stall)
  );

  fw_resolve #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TNEW_W(TNEW_W)) u_rt (
    .addr      (bus.d_rt_addr),
    .tuse      (bus.d_rt_tuse),
    .slot_addr (slot_addr),
    .slot_tnew (slot_tnew),
    .fw_value  (fw_value),
    .grf_data  (bus.grf_rt_data),
    .data      (bus.rt_data),
    .src       (rt_src_sel),
    .pending   (bus.rt_pending),
    .stall     (rt_stall)
  );

  assign stall           = rs_stall | rt_stall;
  assign bus.stall       = stall;
  assign bus.rs_src      = rs_src_sel;
  assign bus.rt_src      = rt_src_sel;
  assign bus.sb_mismatch = sb_mismatch_q;
  assign bus.stall_cnt   = stall_cnt_q;

  // A ready slot must agree with the address its pipeline register forwards.
  always_comb begin
    check_fail = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (slot_tnew[i] == '0 && slot_addr[i] != '0 && fw_addr[i] != slot_addr[i])
        check_fail = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        slot_addr[i] <= '0;
        slot_tnew[i] <= '0;
      end
      sb_mismatch_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so each slot shifts from its pre-edge neighbour.
      slot_addr[2] <= slot_addr[1];
      slot_tnew[2] <= sat_dec(slot_tnew[1]);
      slot_addr[1] <= slot_addr[0];
      slot_tnew[1] <= sat_dec(slot_tnew[0]);
      slot_addr[0] <= stall ? '0 : bus.d_dst_addr;
      slot_tnew[0] <= stall ? '0 : bus.d_dst_tnew;
      if (check_fail)
        sb_mismatch_q <= 1'b1;
      if (stall && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fw_scoreboard.sv
// Self-checking bench for fw_scoreboard: directed scenarios plus random
// traffic, compared against an instruction-history model of the pipeline.
`timescale 1ns/1ps
module tb_fw_scoreboard;
  import fw_scoreboard_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fw_scoreboard_if bus ();
  fw_scoreboard_if #(.CNT_W(4)) bus_sat ();

  fw_scoreboard dut (.clk(clk), .reset(reset), .bus(bus));
  // Narrow-counter copy fed the same stimulus, so saturation is reachable.
  fw_scoreboard #(.CNT_W(4)) dut_sat (.clk(clk), .reset(reset), .bus(bus_sat));

  assign bus_sat.d_rs_addr   = bus.d_rs_addr;
  assign bus_sat.d_rt_addr   = bus.d_rt_addr;
  assign bus_sat.d_rs_tuse   = bus.d_rs_tuse;
  assign bus_sat.d_rt_tuse   = bus.d_rt_tuse;
  assign bus_sat.d_dst_addr  = bus.d_dst_addr;
  assign bus_sat.d_dst_tnew  = bus.d_dst_tnew;
  assign bus_sat.grf_rs_data = bus.grf_rs_data;
  assign bus_sat.grf_rt_data = bus.grf_rt_data;
  assign bus_sat.e_fw_addr   = bus.e_fw_addr;
  assign bus_sat.e_fw_value  = bus.e_fw_value;
  assign bus_sat.m_fw_addr   = bus.m_fw_addr;
  assign bus_sat.m_fw_value  = bus.m_fw_value;
  assign bus_sat.w_fw_addr   = bus.w_fw_addr;
  assign bus_sat.w_fw_value  = bus.w_fw_value;

  int n_checks = 0;
  int n_err    = 0;

  // Model: the last three instructions that entered E (k = edges ago - 1),
  // kept with their Tnew at entry; remaining Tnew is derived from age.
  logic [4:0] h_addr [3];
  int         h_tnew [3];
  bit         m_mm;
  int         m_cnt;
  bit         m_stall;
  bit         hold_fw;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
    logic        pending;
    logic        stall;
  } res_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int age_tnew(input int k);
    return (h_tnew[k] > k) ? h_tnew[k] - k : 0;
  endfunction

  function automatic logic [31:0] fw_val(input int k);
    return (k == 0) ? bus.e_fw_value : (k == 1) ? bus.m_fw_value : bus.w_fw_value;
  endfunction

  function automatic logic [4:0] fw_adr(input int k);
    return (k == 0) ? bus.e_fw_addr : (k == 1) ? bus.m_fw_addr : bus.w_fw_addr;
  endfunction

  function automatic res_t resolve(input logic [4:0] a, input logic [1:0] tuse,
                                   input logic [31:0] grf);
    res_t r;
    r.data = grf; r.src = 2'd0; r.pending = 1'b0; r.stall = 1'b0;
    if (a == 5'd0 || tuse == 2'd3) return r;
    for (int k = 0; k < 3; k++) begin
      if (h_addr[k] == a) begin
        if (age_tnew(k) == 0) begin
          r.src  = 2'(k + 1);
          r.data = fw_val(k);
        end else if (age_tnew(k) <= int'(tuse)) begin
          r.pending = 1'b1;
        end else begin
          r.stall = 1'b1;
        end
        return r;
      end
    end
    return r;
  endfunction

  task automatic set_d(input logic [4:0] rs, input logic [1:0] rs_tuse,
                       input logic [4:0] rt, input logic [1:0] rt_tuse,
                       input logic [4:0] dst, input logic [1:0] tnew);
    bus.d_rs_addr = rs;  bus.d_rs_tuse = rs_tuse;
    bus.d_rt_addr = rt;  bus.d_rt_tuse = rt_tuse;
    bus.d_dst_addr = dst; bus.d_dst_tnew = tnew;
  endtask

  task automatic idle();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd0);
  endtask

  // Ready slots get a matching forward address; others get noise.
  task automatic set_fw();
    bus.e_fw_addr = (age_tnew(0) == 0) ? h_addr[0] : 5'($urandom);
    bus.m_fw_addr = (age_tnew(1) == 0) ? h_addr[1] : 5'($urandom);
    bus.w_fw_addr = (age_tnew(2) == 0) ? h_addr[2] : 5'($urandom);
  endtask

  task automatic prep();
    if (!hold_fw) set_fw();
  endtask

  task automatic sample();
    res_t rs, rt;
    @(negedge clk);
    rs = resolve(bus.d_rs_addr, bus.d_rs_tuse, bus.grf_rs_data);
    rt = resolve(bus.d_rt_addr, bus.d_rt_tuse, bus.grf_rt_data);
    m_stall = rs.stall | rt.stall;
    check("stall",      32'(bus.stall),      32'(m_stall));
    check("rs_data",    bus.rs_data,         rs.data);
    check("rs_src",     32'(bus.rs_src),     32'(rs.src));
    check("rs_pending", 32'(bus.rs_pending), 32'(rs.pending));
    check("rt_data",    bus.rt_data,         rt.data);
    check("rt_src",     32'(bus.rt_src),     32'(rt.src));
    check("rt_pending", 32'(bus.rt_pending), 32'(rt.pending));
    check("sb_mismatch", 32'(bus.sb_mismatch), 32'(m_mm));
    check("stall_cnt",  32'(bus.stall_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    check("stall_cnt4", 32'(bus_sat.stall_cnt), 32'((m_cnt > 15) ? 15 : m_cnt));
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 3; k++) begin h_addr[k] = 5'd0; h_tnew[k] = 0; end
      m_mm  = 1'b0;
      m_cnt = 0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (age_tnew(k) == 0 && h_addr[k] != 5'd0 && fw_adr(k) != h_addr[k]) m_mm = 1'b1;
      if (m_stall) m_cnt++;
      h_addr[2] = h_addr[1]; h_tnew[2] = h_tnew[1];
      h_addr[1] = h_addr[0]; h_tnew[1] = h_tnew[0];
      h_addr[0] = m_stall ? 5'd0 : bus.d_dst_addr;
      h_tnew[0] = m_stall ? 0 : int'(bus.d_dst_tnew);
    end
    #1;
  endtask

  task automatic cycle();
    prep(); sample(); advance();
  endtask

  task automatic do_reset();
    reset = 1'b1; cycle(); reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin h_addr[k] = 5'd0; h_tnew[k] = 0; end
    m_mm = 1'b0; m_cnt = 0; m_stall = 1'b0; hold_fw = 1'b0;
    idle();
    bus.grf_rs_data = 32'h1111_1111;
    bus.grf_rt_data = 32'h2222_2222;
    bus.e_fw_value  = 32'h3008;
    bus.m_fw_value  = 32'hABCD;
    bus.w_fw_value  = 32'h1234;
    bus.e_fw_addr = 5'd0; bus.m_fw_addr = 5'd0; bus.w_fw_addr = 5'd0;
    #1;
    do_reset();

    prep(); sample();
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_mismatch",  32'(bus.sb_mismatch), 32'd0);
    advance();

    // lw $1 then beq $1,$0: two stalls, then bypass from W.
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd1, TNEW_LW); cycle();
    set_d(5'd1, TUSE_BEQ, 5'd0, TUSE_BEQ, 5'd0, 2'd0);
    prep(); sample(); check("lw_beq_stall1", 32'(bus.stall), 32'd1); advance();
    prep(); sample(); check("lw_beq_stall2", 32'(bus.stall), 32'd1); advance();
    prep(); sample();
    check("lw_beq_nostall", 32'(bus.stall),     32'd0);
    check("lw_beq_src",     32'(bus.rs_src),    32'(SRC_W));
    check("lw_beq_data",    bus.rs_data,        32'h1234);
    check("lw_beq_cnt",     32'(bus.stall_cnt), 32'd2);
    advance();

    // ori $2 then addu $3,$2,$2: pending, then M bypass.
    set_d(5'd0, TUSE_ALU, 5'd0, TUSE_NONE, 5'd2, TNEW_ALU); cycle();
    set_d(5'd2, TUSE_ALU, 5'd2, TUSE_ALU, 5'd3, TNEW_ALU);
    prep(); sample();
    check("addu_nostall",   32'(bus.stall),      32'd0);
    check("addu_rs_pend",   32'(bus.rs_pending), 32'd1);
    check("addu_rt_pend",   32'(bus.rt_pending), 32'd1);
    advance();
    set_d(5'd2, TUSE_ALU, 5'd2, TUSE_SW_DATA, 5'd0, 2'd0);
    prep(); sample();
    check("addu_rs_src",  32'(bus.rs_src), 32'(SRC_M));
    check("addu_rs_data", bus.rs_data,     32'hABCD);
    check("addu_same_reg", bus.rt_data,    32'hABCD);
    advance();

    // jal then read $31 with Tuse 0: E bypass.
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd31, TNEW_JAL); cycle();
    set_d(5'd31, TUSE_BEQ, 5'd0, TUSE_NONE, 5'd0, 2'd0);
    prep(); sample();
    check("jal_src",     32'(bus.rs_src), 32'(SRC_E));
    check("jal_data",    bus.rs_data,     32'h3008);
    check("jal_nostall", 32'(bus.stall),  32'd0);
    advance();

    // Two producers of $4: the nearer (E, not ready) wins and stalls.
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd4, TNEW_ALU); cycle();
    cycle();
    set_d(5'd4, TUSE_BEQ, 5'd0, TUSE_BEQ, 5'd0, 2'd0);
    prep(); sample();
    check("dup_stall",   32'(bus.stall),  32'd1);
    check("dup_rs_src",  32'(bus.rs_src), 32'(SRC_GRF));
    check("dup_rs_data", bus.rs_data,     32'h1111_1111);
    check("r0_rt_src",   32'(bus.rt_src), 32'(SRC_GRF));
    check("r0_rt_data",  bus.rt_data,     32'h2222_2222);
    advance();

    // Reset while a stall is being requested with populated slots.
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd7, TNEW_LW); cycle();
    set_d(5'd7, TUSE_BEQ, 5'd7, TUSE_BEQ, 5'd0, 2'd0);
    reset = 1'b1; prep(); sample(); advance(); reset = 1'b0;
    prep(); sample();
    check("rst_mid_stall",  32'(bus.stall),       32'd0);
    check("rst_mid_cnt",    32'(bus.stall_cnt),   32'd0);
    check("rst_mid_mm",     32'(bus.sb_mismatch), 32'd0);
    advance();

    // M slot {5, tnew 0} while the M register forwards $6.
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd5, TNEW_ALU); cycle();
    idle(); cycle();
    set_fw(); bus.m_fw_addr = 5'd6; hold_fw = 1'b1;
    sample(); advance(); hold_fw = 1'b0;
    prep(); sample(); check("mm_set", 32'(bus.sb_mismatch), 32'd1); advance();
    for (int i = 0; i < 3; i++) cycle();
    prep(); sample(); check("mm_sticky", 32'(bus.sb_mismatch), 32'd1); advance();
    do_reset();
    prep(); sample(); check("mm_cleared", 32'(bus.sb_mismatch), 32'd0); advance();

    // Random traffic over a small register range to force collisions.
    for (int i = 0; i < 400; i++) begin
      set_d(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 2'(($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2)));
      bus.grf_rs_data = $urandom; bus.grf_rt_data = $urandom;
      bus.e_fw_value  = $urandom; bus.m_fw_value  = $urandom; bus.w_fw_value = $urandom;
      reset = ($urandom_range(0, 60) == 0);
      cycle();
    end
    reset = 1'b0;

    // Back-to-back Tnew-3 producers read at Tuse 0 stall even from W.
    do_reset();
    set_d(5'd1, TUSE_BEQ, 5'd0, TUSE_NONE, 5'd1, 2'd3);
    for (int i = 0; i < 40; i++) cycle();
    prep(); sample();
    check("sat4_cnt", 32'(bus_sat.stall_cnt), 32'd15);
    check("sat_total", 32'(bus.stall_cnt), 32'd30);
    advance();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
